// File: rtl/data_stack_pkg.sv
// Shared constants for the Forth data stack: stack-control opcodes,
// fault codes and the depth-counter width helper.
package data_stack_pkg;

  localparam logic [2:0] STK_NOP    = 3'b000;
  localparam logic [2:0] STK_PUSH   = 3'b001;
  localparam logic [2:0] STK_DROP   = 3'b010;
  localparam logic [2:0] STK_DUP    = 3'b011;
  localparam logic [2:0] STK_SWAP   = 3'b100;
  localparam logic [2:0] STK_OVER   = 3'b101;
  localparam logic [2:0] STK_UNARY  = 3'b110;
  localparam logic [2:0] STK_BINARY = 3'b111;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;

  // Bits needed to count 0..depth inclusive.
  function automatic int depth_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/data_stack_spill_ram.sv
// Spill storage below NOS: WORDS x WIDTH, synchronous write, asynchronous read.
module stack_spill_ram #(
  parameter int WIDTH = 16,
  parameter int WORDS = 14,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/data_stack.sv
// Forth parameter stack feeding the ALU with TOS/NOS and absorbing its result.
// Optional fault latch enabled by defining STACK_GUARD_EN.
module data_stack
  import data_stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                          c_CLOCK,
  input  logic                          c_RESET_N,
  input  logic [2:0]                    f_stackctrl,
  input  logic [WIDTH-1:0]              i_DATA,
  input  logic [WIDTH-1:0]              i_RESULT,
  output logic [WIDTH-1:0]              o_TOS,
  output logic [WIDTH-1:0]              o_NOS,
  output logic [depth_width(DEPTH)-1:0] o_DEPTH,
  output logic                          o_EMPTY,
  output logic                          o_FULL,
  output logic                          o_ERROR,
  output logic [1:0]                    o_ERRCODE
);

  localparam int DW = depth_width(DEPTH);
  localparam int SD = DEPTH - 2;
  localparam int AW = (SD > 1) ? $clog2(SD) : 1;

  logic [WIDTH-1:0] tos_q, tos_d, nos_q, nos_d;
  logic [WIDTH-1:0] spill_rdata, push_val;
  logic [DW-1:0]    depth_q, depth_d, spill_ptr;
  logic             spill_we, do_push;
  logic             empty, full, lt2, underflow, overflow;

  assign empty     = (depth_q == '0);
  assign full      = (depth_q == DW'(DEPTH));
  assign lt2       = (depth_q < DW'(2));
  assign spill_ptr = lt2 ? '0 : depth_q - DW'(2);

  stack_spill_ram #(
    .WIDTH (WIDTH),
    .WORDS (SD),
    .AW    (AW)
  ) u_spill (
    .clk_i   (c_CLOCK),
    .we_i    (spill_we),
    .waddr_i (AW'(spill_ptr)),
    .wdata_i (nos_q),
    .raddr_i (AW'(spill_ptr - DW'(1))),
    .rdata_o (spill_rdata)
  );

  // Underflow is evaluated first so it wins when both could apply.
  always_comb begin
    underflow = 1'b0;
    overflow  = 1'b0;
    case (f_stackctrl)
      STK_PUSH:   overflow  = full;
      STK_DROP:   underflow = empty;
      STK_DUP:    begin underflow = empty; overflow = !empty && full; end
      STK_SWAP:   underflow = lt2;
      STK_OVER:   begin underflow = lt2; overflow = !lt2 && full; end
      STK_UNARY:  underflow = empty;
      STK_BINARY: underflow = lt2;
      default:    ;
    endcase
  end

  always_comb begin
    tos_d    = tos_q;
    nos_d    = nos_q;
    depth_d  = depth_q;
    spill_we = 1'b0;
    do_push  = 1'b0;
    push_val = i_DATA;
    if (!(underflow || overflow)) begin
      case (f_stackctrl)
        STK_PUSH: do_push = 1'b1;
        STK_DROP: begin
          tos_d   = nos_q;
          if (depth_q >= DW'(3)) nos_d = spill_rdata;
          depth_d = depth_q - DW'(1);
        end
        STK_DUP:  begin do_push = 1'b1; push_val = tos_q; end
        STK_SWAP: begin tos_d = nos_q; nos_d = tos_q; end
        STK_OVER: begin do_push = 1'b1; push_val = nos_q; end
        STK_UNARY: tos_d = i_RESULT;
        STK_BINARY: begin
          tos_d   = i_RESULT;
          if (depth_q >= DW'(3)) nos_d = spill_rdata;
          depth_d = depth_q - DW'(1);
        end
        default: ;
      endcase
      // PUSH, DUP and OVER share one shift-down path.
      if (do_push) begin
        spill_we = !lt2;
        nos_d    = tos_q;
        tos_d    = push_val;
        depth_d  = depth_q + DW'(1);
      end
    end
  end

  always_ff @(posedge c_CLOCK or negedge c_RESET_N) begin
    if (!c_RESET_N) begin
      tos_q   <= '0;
      nos_q   <= '0;
      depth_q <= '0;
    end else begin
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      depth_q <= depth_d;
    end
  end

`ifdef STACK_GUARD_EN
  logic       err_q;
  logic [1:0] errcode_q;

  always_ff @(posedge c_CLOCK or negedge c_RESET_N) begin
    if (!c_RESET_N) begin
      err_q     <= 1'b0;
      errcode_q <= ERR_NONE;
    end else if (!err_q && (underflow || overflow)) begin
      err_q     <= 1'b1;
      errcode_q <= underflow ? ERR_UNDER : ERR_OVER;
    end
  end

  assign o_ERROR   = err_q;
  assign o_ERRCODE = errcode_q;
`else
  assign o_ERROR   = 1'b0;
  assign o_ERRCODE = ERR_NONE;
`endif

  assign o_TOS   = tos_q;
  assign o_NOS   = nos_q;
  assign o_DEPTH = depth_q;
  assign o_EMPTY = empty;
  assign o_FULL  = full;

endmodule

// File: tb/tb_data_stack.sv
// Directed, table-driven bench for data_stack plus fill/overflow and async-reset sequences.
module tb_data_stack;
  import data_stack_pkg::*;

`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  ctrl = STK_NOP;
  logic [15:0] data = '0;
  logic [15:0] result = '0;
  logic [15:0] tos, nos;
  logic [4:0]  depth;
  logic        empty, full, err;
  logic [1:0]  errcode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_stack #(.WIDTH(16), .DEPTH(16)) dut (
    .c_CLOCK     (clk),
    .c_RESET_N   (rst_n),
    .f_stackctrl (ctrl),
    .i_DATA      (data),
    .i_RESULT    (result),
    .o_TOS       (tos),
    .o_NOS       (nos),
    .o_DEPTH     (depth),
    .o_EMPTY     (empty),
    .o_FULL      (full),
    .o_ERROR     (err),
    .o_ERRCODE   (errcode)
  );

  typedef struct {
    logic [2:0]  op;
    logic [15:0] data;
    logic [15:0] res;
    logic [15:0] tos;
    logic [15:0] nos;
    logic [4:0]  depth;
    bit          chk_nos;
    bit          err;
    logic [1:0]  code;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] op, input logic [15:0] d, input logic [15:0] r,
                     input logic [15:0] t, input logic [15:0] n, input logic [4:0] dp,
                     input bit cn, input bit e, input logic [1:0] c);
    vec_t v;
    v.op = op; v.data = d; v.res = r; v.tos = t; v.nos = n;
    v.depth = dp; v.chk_nos = cn; v.err = e; v.code = c;
    vecs.push_back(v);
  endtask

  // Drive at negedge, let one posedge take it, sample at the following negedge.
  task automatic step(input logic [2:0] op, input logic [15:0] d, input logic [15:0] r);
    ctrl = op; data = d; result = r;
    @(negedge clk);
    ctrl = STK_NOP;
  endtask

  task automatic check_err(input string name, input bit e, input logic [1:0] c);
    chk({name, ".err"}, {31'd0, err}, {31'd0, GUARD ? e : 1'b0});
    chk({name, ".code"}, {30'd0, errcode}, {30'd0, GUARD ? c : ERR_NONE});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ctrl = STK_NOP;
    repeat (2) @(negedge clk);
    chk("rst.tos", {16'd0, tos}, 32'd0);
    chk("rst.nos", {16'd0, nos}, 32'd0);
    chk("rst.depth", {27'd0, depth}, 32'd0);
    chk("rst.empty", {31'd0, empty}, 32'd1);
    check_err("rst", 1'b0, ERR_NONE);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    // op, data, result, exp tos, exp nos, exp depth, check nos, err, code
    add(STK_PUSH,   16'd5,  16'd0,      16'd5,      16'd0,      5'd1, 0, 0, ERR_NONE);
    add(STK_PUSH,   16'd7,  16'd0,      16'd7,      16'd5,      5'd2, 1, 0, ERR_NONE);
    add(STK_BINARY, 16'd0,  16'd12,     16'd12,     16'd0,      5'd1, 0, 0, ERR_NONE);
    add(STK_DROP,   16'd0,  16'd0,      16'd5,      16'd0,      5'd0, 0, 0, ERR_NONE);
    add(STK_PUSH,   16'd1,  16'd0,      16'd1,      16'd0,      5'd1, 0, 0, ERR_NONE);
    add(STK_PUSH,   16'd2,  16'd0,      16'd2,      16'd1,      5'd2, 1, 0, ERR_NONE);
    add(STK_PUSH,   16'd3,  16'd0,      16'd3,      16'd2,      5'd3, 1, 0, ERR_NONE);
    add(STK_PUSH,   16'd4,  16'd0,      16'd4,      16'd3,      5'd4, 1, 0, ERR_NONE);
    add(STK_SWAP,   16'd0,  16'd0,      16'd3,      16'd4,      5'd4, 1, 0, ERR_NONE);
    add(STK_DROP,   16'd0,  16'd0,      16'd4,      16'd2,      5'd3, 1, 0, ERR_NONE);
    add(STK_DROP,   16'd0,  16'd0,      16'd2,      16'd1,      5'd2, 1, 0, ERR_NONE);
    add(STK_DROP,   16'd0,  16'd0,      16'd1,      16'd0,      5'd1, 0, 0, ERR_NONE);
    add(STK_DROP,   16'd0,  16'd0,      16'd1,      16'd0,      5'd0, 0, 0, ERR_NONE);
    add(STK_DROP,   16'd0,  16'd0,      16'd1,      16'd0,      5'd0, 0, 1, ERR_UNDER);
    add(STK_PUSH,   16'd9,  16'd0,      16'd9,      16'd1,      5'd1, 0, 1, ERR_UNDER);
    add(STK_DROP,   16'd0,  16'd0,      16'd1,      16'd0,      5'd0, 0, 1, ERR_UNDER);
    add(STK_PUSH,   16'd3,  16'd0,      16'd3,      16'd0,      5'd1, 0, 1, ERR_UNDER);
    add(STK_DUP,    16'd0,  16'd0,      16'd3,      16'd3,      5'd2, 1, 1, ERR_UNDER);
    add(STK_OVER,   16'd0,  16'd0,      16'd3,      16'd3,      5'd3, 1, 1, ERR_UNDER);
    add(STK_UNARY,  16'd0,  16'hFFFD,   16'hFFFD,   16'd3,      5'd3, 1, 1, ERR_UNDER);
    add(STK_SWAP,   16'd0,  16'd0,      16'd3,      16'hFFFD,   5'd3, 1, 1, ERR_UNDER);
    add(STK_BINARY, 16'd0,  16'h1234,   16'h1234,   16'd3,      5'd2, 1, 1, ERR_UNDER);
    add(STK_BINARY, 16'd0,  16'hAAAA,   16'hAAAA,   16'd3,      5'd1, 0, 1, ERR_UNDER);
    add(STK_SWAP,   16'd0,  16'd0,      16'hAAAA,   16'd3,      5'd1, 0, 1, ERR_UNDER);
    add(STK_NOP,    16'hBEEF, 16'hBEEF, 16'hAAAA,   16'd3,      5'd1, 0, 1, ERR_UNDER);

    do_reset();

    foreach (vecs[i]) begin
      step(vecs[i].op, vecs[i].data, vecs[i].res);
      chk($sformatf("v%0d.tos", i), {16'd0, tos}, {16'd0, vecs[i].tos});
      if (vecs[i].chk_nos) chk($sformatf("v%0d.nos", i), {16'd0, nos}, {16'd0, vecs[i].nos});
      chk($sformatf("v%0d.depth", i), {27'd0, depth}, {27'd0, vecs[i].depth});
      chk($sformatf("v%0d.empty", i), {31'd0, empty}, {31'd0, vecs[i].depth == 5'd0});
      check_err($sformatf("v%0d", i), vecs[i].err, vecs[i].code);
      $display("vec %0d op=%0d tos=0x%04h nos=0x%04h depth=%0d err=%0d code=%0d",
               i, vecs[i].op, tos, nos, depth, err, errcode);
    end

    // Fill to capacity, overflow once, then drain to confirm spill ordering.
    do_reset();
    for (int k = 1; k <= 16; k++) step(STK_PUSH, 16'(k), 16'd0);
    chk("fill.depth", {27'd0, depth}, 32'd16);
    chk("fill.full", {31'd0, full}, 32'd1);
    chk("fill.tos", {16'd0, tos}, 32'h10);
    chk("fill.nos", {16'd0, nos}, 32'h0F);
    step(STK_PUSH, 16'hFFFF, 16'd0);
    chk("ovf.depth", {27'd0, depth}, 32'd16);
    chk("ovf.tos", {16'd0, tos}, 32'h10);
    chk("ovf.nos", {16'd0, nos}, 32'h0F);
    check_err("ovf", 1'b1, ERR_OVER);
    $display("overflow push: tos=0x%04h depth=%0d err=%0d code=%0d", tos, depth, err, errcode);
    step(STK_DUP, 16'd0, 16'd0);
    chk("ovfdup.depth", {27'd0, depth}, 32'd16);
    for (int k = 15; k >= 0; k--) begin
      step(STK_DROP, 16'd0, 16'd0);
      chk($sformatf("drain%0d.depth", k), {27'd0, depth}, 32'(k));
      if (k >= 1) chk($sformatf("drain%0d.tos", k), {16'd0, tos}, 32'(k));
      $display("drain: tos=0x%04h depth=%0d", tos, depth);
    end
    chk("drain.empty", {31'd0, empty}, 32'd1);
    check_err("drain", 1'b1, ERR_OVER);

    // Asynchronous reset in the middle of a clock period at depth 5.
    do_reset();
    for (int k = 0; k < 5; k++) step(STK_PUSH, 16'h100 + 16'(k), 16'd0);
    chk("pre.depth", {27'd0, depth}, 32'd5);
    chk("pre.tos", {16'd0, tos}, 32'h104);
    step(STK_SWAP, 16'd0, 16'd0);
    step(STK_SWAP, 16'd0, 16'd0);
    step(STK_DROP, 16'd0, 16'd0);
    step(STK_DROP, 16'd0, 16'd0);
    step(STK_DROP, 16'd0, 16'd0);
    step(STK_DROP, 16'd0, 16'd0);
    step(STK_DROP, 16'd0, 16'd0);
    step(STK_DROP, 16'd0, 16'd0);
    check_err("preasync", 1'b1, ERR_UNDER);
    for (int k = 0; k < 5; k++) step(STK_PUSH, 16'h200 + 16'(k), 16'd0);
    ctrl = STK_PUSH; data = 16'h5555;
    #2 rst_n = 1'b0;
    #1;
    chk("async.tos", {16'd0, tos}, 32'd0);
    chk("async.nos", {16'd0, nos}, 32'd0);
    chk("async.depth", {27'd0, depth}, 32'd0);
    chk("async.empty", {31'd0, empty}, 32'd1);
    check_err("async", 1'b0, ERR_NONE);
    $display("async reset: tos=0x%04h depth=%0d err=%0d", tos, depth, err);
    @(negedge clk);
    ctrl = STK_NOP;
    chk("async.hold", {27'd0, depth}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
